// File: rtl/bmp180_i2c_target.sv
// BMP180 pressure-sensor emulator on the I2C target side: decodes bus traffic,
// serves the register map and reports conversion requests.
module bmp180_i2c_target #(
    parameter logic [6:0]   ADR     = 7'h77,
    parameter logic [7:0]   CHIP_ID = 8'h55,
    parameter logic [175:0] CALIB   = 176'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [23:0] meas_data,
    input  logic        meas_valid,
    output logic [7:0]  ctrl_meas,
    output logic        conv_req,
    output logic        busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StReg, StRegAck,
        StWData, StWDataAck, StRData, StRDataAck, StWait
    } state_e;

    state_e      stateQ, stateD;
    logic [1:0]  sclPipe, sdaPipe;
    logic        sclPrev, sdaPrev;
    logic        sclNow, sdaNow;
    logic        sclRise, sclFall, startCond, stopCond;
    logic [3:0]  bitCntQ;
    logic [7:0]  shiftQ, txQ, ptrQ;
    logic [7:0]  ctrlMeasQ;
    logic [23:0] measQ;
    logic        sdaOeQ, sdaOeD;
    logic        convReqQ;
    logic [7:0]  loadPtr, rdByte;
    logic        loadByte, ptrLoad, wrCommit, ptrInc;
    logic        wrCtrl, softRst;

    // Synchronizers idle high so reset release never fakes a bus condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclPipe <= 2'b11;
            sdaPipe <= 2'b11;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclPipe <= {sclPipe[0], scl};
            sdaPipe <= {sdaPipe[0], sda_in};
            sclPrev <= sclPipe[1];
            sdaPrev <= sdaPipe[1];
        end
    end

    assign sclNow    = sclPipe[1];
    assign sdaNow    = sdaPipe[1];
    assign sclRise   = sclNow & ~sclPrev;
    assign sclFall   = ~sclNow & sclPrev;
    assign startCond = sclNow & sclPrev & sdaPrev & ~sdaNow;
    assign stopCond  = sclNow & sclPrev & ~sdaPrev & sdaNow;

    // Read mux; the byte after an ACKed read comes from the next pointer.
    assign loadPtr = (stateQ == StRDataAck) ? ptrQ + 8'd1 : ptrQ;

    always_comb begin
        rdByte = 8'h00;
        if (loadPtr == 8'hD0) begin
            rdByte = CHIP_ID;
        end else begin
            case (loadPtr)
                8'hF4:   rdByte = ctrlMeasQ;
                8'hF6:   rdByte = measQ[23:16];
                8'hF7:   rdByte = measQ[15:8];
                8'hF8:   rdByte = measQ[7:0];
                default: rdByte = 8'h00;
            endcase
            for (int i = 0; i < 22; i++) begin
                if (loadPtr == 8'hAA + 8'(i)) rdByte = CALIB[8*(21-i) +: 8];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateQ <= StIdle;
        else        stateQ <= stateD;
    end

    // FSM next state
    always_comb begin
        stateD = stateQ;
        if (stopCond) begin
            stateD = StIdle;
        end else if (startCond) begin
            stateD = StAddr;
        end else if (sclFall) begin
            case (stateQ)
                StAddr: begin
                    if (bitCntQ == 4'd8) begin
                        stateD = (shiftQ[7:1] == ADR) ? StAddrAck : StWait;
                    end
                end
                StAddrAck:  stateD = shiftQ[0] ? StRData : StReg;
                StReg:      if (bitCntQ == 4'd8) stateD = StRegAck;
                StRegAck:   stateD = StWData;
                StWData:    if (bitCntQ == 4'd8) stateD = StWDataAck;
                StWDataAck: stateD = StWData;
                StRData:    if (bitCntQ == 4'd8) stateD = StRDataAck;
                StRDataAck: stateD = shiftQ[0] ? StWait : StRData;
                default:    stateD = stateQ;
            endcase
        end
    end

    // FSM outputs and datapath strobes
    always_comb begin
        sdaOeD   = sdaOeQ;
        loadByte = 1'b0;
        ptrLoad  = 1'b0;
        wrCommit = 1'b0;
        ptrInc   = 1'b0;
        busy     = stateQ inside {StAddrAck, StReg, StRegAck, StWData, StWDataAck,
                                  StRData, StRDataAck};
        if (startCond || stopCond) begin
            sdaOeD = 1'b0;
        end else if (sclFall) begin
            case (stateD)
                StAddrAck, StRegAck, StWDataAck: sdaOeD = 1'b1;
                StRData: sdaOeD = (stateQ == StRData) ? ~txQ[6] : ~rdByte[7];
                default: sdaOeD = 1'b0;
            endcase
            loadByte = (stateD == StRData) && (stateQ != StRData);
            ptrLoad  = (stateQ == StReg) && (stateD == StRegAck);
            wrCommit = (stateQ == StWData) && (stateD == StWDataAck);
            ptrInc   = wrCommit || ((stateQ == StRDataAck) && (stateD == StRData));
        end
    end

    assign wrCtrl  = wrCommit && (ptrQ == 8'hF4);
    assign softRst = wrCommit && (ptrQ == 8'hE0) && (shiftQ == 8'hB6);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitCntQ   <= 4'd0;
            shiftQ    <= 8'h00;
            txQ       <= 8'h00;
            ptrQ      <= 8'h00;
            sdaOeQ    <= 1'b0;
            ctrlMeasQ <= 8'h00;
            measQ     <= 24'h0;
            convReqQ  <= 1'b0;
        end else begin
            sdaOeQ   <= sdaOeD;
            convReqQ <= wrCtrl && shiftQ[5];

            if (startCond || (sclFall && (stateD != stateQ))) begin
                bitCntQ <= 4'd0;
            end else if (sclRise && (stateQ inside {StAddr, StReg, StWData, StRData})) begin
                bitCntQ <= bitCntQ + 4'd1;
            end

            if (sclRise && (stateQ inside {StAddr, StReg, StWData, StRDataAck})) begin
                shiftQ <= {shiftQ[6:0], sdaNow};
            end

            if (loadByte) begin
                txQ <= rdByte;
            end else if (sclFall && (stateQ == StRData) && (stateD == StRData)) begin
                txQ <= {txQ[6:0], 1'b0};
            end

            if (ptrLoad)     ptrQ <= shiftQ;
            else if (ptrInc) ptrQ <= ptrQ + 8'd1;

            // A bus write to 0xF4 takes precedence over the SCO clear.
            if (wrCtrl)          ctrlMeasQ <= shiftQ;
            else if (softRst)    ctrlMeasQ <= 8'h00;
            else if (meas_valid) ctrlMeasQ <= ctrlMeasQ & 8'hDF;

            if (meas_valid)   measQ <= meas_data;
            else if (softRst) measQ <= 24'h0;
        end
    end

    assign sda_oe    = sdaOeQ;
    assign ctrl_meas = ctrlMeasQ;
    assign conv_req  = convReqQ;

endmodule

// File: doc/bmp180_i2c_target.md
# bmp180_i2c_target

Synthesizable I2C target that emulates the BMP180 pressure sensor at the bus pins, so the BMP180 query FSM and its I2C master can be exercised in simulation and on-board without the physical chip. Sits on the far side of the I2C bus from the master, decodes START/STOP/address/register-pointer traffic, and serves the BMP180 register map. Measurement results come from a local port; conversion requests are reported back as a pulse.

## Interface
Parameters:
- ADR, 7'h77, 7-bit bus address answered.
- CHIP_ID, 8'h55, value returned at register 0xD0.
- CALIB, 176'h0, calibration bytes 0xAA..0xBF; 0xAA = CALIB[175:168], 0xBF = CALIB[7:0].

Ports:
- clk  in  1  system clock; must be at least 10x the SCL frequency.
- reset  in  1  asynchronous, active-low; all state cleared immediately.
- scl  in  1  bus clock from the master (raw pin).
- sda_in  in  1  bus data (raw pin).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- meas_data  in  24  {MSB, LSB, XLSB} for registers 0xF6..0xF8.
- meas_valid  in  1  one-cycle strobe: load meas_data, clear SCO.
- ctrl_meas  out  8  register 0xF4; bit 5 = SCO.
- conv_req  out  1  one-cycle pulse when 0xF4 is written with bit 5 = 1.
- busy  out  1  high from an address match until STOP, or until the FSM drops to IDLE/WAIT.

## Operation
- scl and sda_in each pass through a 2-FF synchronizer. All edge detection uses the synchronized copies.
- Bus conditions, evaluated every clk:
  - START: SDA falls while SCL is high. Enter ADDR from any state, including repeated START. The register pointer is kept.
  - STOP: SDA rises while SCL is high. Enter IDLE from any state and release SDA.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
  - ADDR: shift 8 bits MSB first on SCL rising edges.
    - Address matches ADR: go to ADDR_ACK and drive ACK.
    - Mismatch: go to WAIT with SDA released. WAIT is left only on START or STOP.
  - ADDR_ACK:
    - W bit: go to REG.
    - R bit: go to RDATA, loading the byte at the pointer.
  - REG: receive 8 bits into the pointer, ACK, then go to WDATA.
  - WDATA: receive a byte, ACK, write it to the pointer, then increment the pointer.
  - RDATA: shift out MSB first, then RDATA_ACK samples the master's bit.
    - ACK (0): increment the pointer and load the next byte.
    - NACK (1): go to WAIT.
- Pointer arithmetic: 8 bits; 0xFF wraps to 0x00.
- Register map, read:
  - 0xD0 returns CHIP_ID.
  - 0xAA..0xBF return CALIB bytes.
  - 0xF4 returns ctrl_meas.
  - 0xF6/0xF7/0xF8 return meas bytes.
  - All other addresses return 0x00.
- Register map, write:
  - 0xF4 writes ctrl_meas.
  - 0xE0 with 0xB6 is a soft reset: ctrl_meas and the meas registers are cleared. Any other value written to 0xE0 is ignored.
  - Writes to all other addresses are ignored, but still ACKed.
- A read byte is sampled from the register file at load time. Later changes do not affect the byte being shifted.
- Simultaneous I2C write to 0xF4 and meas_valid: the I2C write wins for ctrl_meas; the meas registers still load.

## Timing
- Reset values:
  - sda_oe = 0, ctrl_meas = 0x00, conv_req = 0, busy = 0.
  - Pointer = 0x00, meas registers = 0, state = IDLE.
- Sampling: a bit is sampled on the first clk where the synchronized SCL rise is seen (3 clk after the pin edge).
- Driving: sda_oe changes only on the clk after a synchronized SCL fall. SDA is never changed while SCL is high.
- ACK: driven from the SCL fall after bit 8 until the SCL fall after the 9th clock.
- Read byte: loaded on the SCL fall that ends the ADDR ACK, or that ends the master ACK. The first bit is on sda_oe one clk later.
- conv_req: asserted the clk after the WDATA ACK-phase write commit; exactly one clk wide.
- meas_valid: registers update, and SCO clears, on the next clk edge.
- Reset asserted mid-transfer: sda_oe releases immediately (asynchronous). After release, the block ignores bus activity until the next START.

## Test plan
- Read ID: START, 0xEE, 0xD0, repeated START, 0xEF, read 1 byte, NACK, STOP. Required: three ACKs, returned byte 0x55, sda_oe = 0 after STOP.
- Calibration burst: CALIB = 0xA1A2..B6 pattern; set pointer 0xAA and read 22 bytes with ACK. Required: bytes 0xA1..0xB6 in order; a 23rd byte reads 0x00 (pointer at 0xC0).
- Conversion: write 0x2E to 0xF4. Required: ctrl_meas = 0x2E, one conv_req pulse. Then meas_valid with 0x6C_FA_00. Required: ctrl_meas = 0x0E; reading 0xF6 gives 0x6C, 0xFA, 0x00.
- Wrong address 0x76 (byte 0xEC): no ACK, sda_oe stays 0 through STOP; the next 0xEE transfer is ACKed.
- Soft reset: write 0xB6 to 0xE0 after loading 0xF4 = 0x34. Required: ctrl_meas = 0x00. Writing 0x00 to 0xE0 instead leaves ctrl_meas unchanged.
- Reset pulse in the middle of a read byte driving 0: sda_oe = 0 within the same cycle. Bus is ignored until START, then a normal ID read returns 0x55.
